// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-side port logic.
// Holds the register count, status bit layout, default VRAM address width and FSM states.
package vdp_pkg;

    localparam int REG_COUNT  = 8;
    localparam int STAT_F     = 7;
    localparam int STAT_C     = 6;
    localparam int STAT_5S    = 5;
    localparam int DEF_ADDR_W = 14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } vdp_state_t;

endpackage

// File: rtl/vdp_status.sv
// VDP status flags F, C and 5S with the fifth-sprite number.
// A set tick always beats a coincident clear from a status read.
module vdp_status
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       coll_tick,
    input  logic       fifth_tick,
    input  logic [4:0] fifth_num,
    input  logic       clr,
    output logic [7:0] status
);

    logic       f_r;
    logic       c_r;
    logic       s5_r;
    logic [4:0] num_r;

    // Flag registers: set has priority over clear; number frozen while 5S is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_r   <= 1'b0;
            c_r   <= 1'b0;
            s5_r  <= 1'b0;
            num_r <= 5'd0;
        end else begin
            f_r  <= frame_tick | (f_r  & ~clr);
            c_r  <= coll_tick  | (c_r  & ~clr);
            s5_r <= fifth_tick | (s5_r & ~clr);
            if (fifth_tick && !s5_r) begin
                num_r <= fifth_num;
            end
        end
    end

    // Pack flags into the status byte.
    always_comb begin
        status          = {3'b000, num_r};
        status[STAT_F]  = f_r;
        status[STAT_C]  = c_r;
        status[STAT_5S] = s5_r;
    end

endmodule

// File: rtl/vdp_cpu_if.sv
// CPU-facing VDP port decoder: control/data ports, register file, status read,
// and a single-outstanding VRAM request channel with replacement and ack timeout.
module vdp_cpu_if
    import vdp_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_tick,
    input  logic              wr_tick,
    input  logic              mode,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_req,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic [63:0]       regs,
    input  logic              frame_tick,
    input  logic              coll_tick,
    input  logic              fifth_tick,
    input  logic [4:0]        fifth_num,
    output logic              int_n,
    output logic              overrun
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    vdp_state_t        state_r, state_nx;
    logic [ADDR_W-1:0] addr_r, addr_nx, op_addr_s;
    logic [7:0]        lo_byte_r, lo_nx, read_buf_r;
    logic              second_flag_r, second_nx;
    logic [7:0]        regs_r [REG_COUNT];
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [ADDR_W-1:0] vram_addr_r;
    logic [7:0]        vram_wdata_r;
    logic              vram_we_r, overrun_r;
    logic              op_valid_s, op_we_s, reg_we_s, status_clr_s;
    logic              ack_s, replace_s, timeout_s;
    logic [13:0]       ctrl_addr_s;
    logic [7:0]        status_s;

    vdp_status u_status (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .coll_tick  (coll_tick),
        .fifth_tick (fifth_tick),
        .fifth_num  (fifth_num),
        .clr        (status_clr_s),
        .status     (status_s)
    );

    // Port command decode; a write tick masks a simultaneous read tick.
    always_comb begin
        op_valid_s   = 1'b0;
        op_we_s      = 1'b0;
        op_addr_s    = addr_r;
        addr_nx      = addr_r;
        lo_nx        = lo_byte_r;
        second_nx    = second_flag_r;
        reg_we_s     = 1'b0;
        status_clr_s = 1'b0;
        ctrl_addr_s  = {din[5:0], lo_byte_r};
        if (wr_tick) begin
            if (mode) begin
                if (!second_flag_r) begin
                    lo_nx     = din;
                    second_nx = 1'b1;
                end else begin
                    second_nx = 1'b0;
                    if (din[7]) begin
                        reg_we_s = 1'b1;
                    end else begin
                        addr_nx = ADDR_W'(ctrl_addr_s);
                        if (!din[6]) begin
                            op_valid_s = 1'b1;
                            op_addr_s  = addr_nx;
                            addr_nx    = addr_nx + ADDR_ONE;
                        end else begin
                            op_valid_s = 1'b0;
                        end
                    end
                end
            end else begin
                op_valid_s = 1'b1;
                op_we_s    = 1'b1;
                addr_nx    = addr_r + ADDR_ONE;
                second_nx  = 1'b0;
            end
        end else if (rd_tick) begin
            second_nx = 1'b0;
            if (mode) begin
                status_clr_s = 1'b1;
            end else begin
                op_valid_s = 1'b1;
                addr_nx    = addr_r + ADDR_ONE;
            end
        end else begin
            op_valid_s = 1'b0;
        end
    end

    // Request FSM: a new op always (re)arms REQ; otherwise ack or timeout return to IDLE.
    always_comb begin
        state_nx  = state_r;
        ack_s     = 1'b0;
        replace_s = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid_s) begin
                    state_nx = ST_REQ;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                ack_s = vram_ack;
                if (op_valid_s) begin
                    replace_s = ~vram_ack;
                    state_nx  = ST_REQ;
                end else if (vram_ack) begin
                    state_nx = ST_IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    state_nx = ST_REQ;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            lo_byte_r     <= 8'h00;
            second_flag_r <= 1'b0;
            read_buf_r    <= 8'h00;
            tmo_cnt_r     <= '0;
            vram_addr_r   <= '0;
            vram_wdata_r  <= 8'h00;
            vram_we_r     <= 1'b0;
            overrun_r     <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            state_r       <= state_nx;
            addr_r        <= addr_nx;
            lo_byte_r     <= lo_nx;
            second_flag_r <= second_nx;
            if (reg_we_s) begin
                regs_r[din[2:0]] <= lo_byte_r;
            end
            if (op_valid_s) begin
                vram_addr_r  <= op_addr_s;
                vram_we_r    <= op_we_s;
                vram_wdata_r <= op_we_s ? din : 8'h00;
                tmo_cnt_r    <= '0;
            end else if (state_r == ST_REQ) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end
            // A CPU data write overrides read data returning in the same cycle.
            if (op_valid_s && op_we_s) begin
                read_buf_r <= din;
            end else if (ack_s && !vram_we_r) begin
                read_buf_r <= vram_rdata;
            end
            if (replace_s || timeout_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        regs = 64'd0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs[8*i +: 8] = regs_r[i];
        end
    end

    assign dout       = mode ? status_s : read_buf_r;
    assign vram_addr  = vram_addr_r;
    assign vram_wdata = vram_wdata_r;
    assign vram_we    = vram_we_r;
    assign vram_req   = (state_r == ST_REQ);
    assign overrun    = overrun_r;
    assign int_n      = ~(status_s[STAT_F] & regs_r[1][5]);

endmodule
